// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and types for the integer register file with scoreboard
package reg_file_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int REG_ZERO = 0;
  typedef logic [4:0] reg_addr_t;
  typedef logic [31:0] reg_data_t;
endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: read, write-back and issue ports of the register file
interface reg_file_sb_if import reg_file_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic [ADDR_W-1:0] rs1_addr, rs2_addr, rd_addr, issue_rd;
  logic [XLEN-1:0] rs1_data, rs2_data, rd_data;
  logic rs1_busy, rs2_busy, we, issue_valid, issue_conflict;
  modport master (
    output rs1_addr, rs2_addr, we, rd_addr, rd_data, issue_valid, issue_rd,
    input rs1_data, rs2_data, rs1_busy, rs2_busy, issue_conflict
  );
  modport slave (
    input rs1_addr, rs2_addr, we, rd_addr, rd_data, issue_valid, issue_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, issue_conflict
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: per-register busy bits; a new reservation wins over a same-cycle write-back
module reg_file_scoreboard import reg_file_pkg::*; #(
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic we,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr,
  input  logic issue_valid,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
  output logic [NUM_REGS-1:0] busy,
  output logic issue_conflict
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic [NUM_REGS-1:0] set_mask, clr_mask;
  logic issue_ok;
  always_comb begin
    issue_ok = issue_valid && issue_rd != ADDR_W'(REG_ZERO);
    set_mask = issue_ok ? NUM_REGS'(1) << issue_rd : '0;
    clr_mask = we ? NUM_REGS'(1) << rd_addr : '0;
    issue_conflict = issue_ok && busy[issue_rd];
  end
  always_ff @(posedge clk)
    if (n_rst) busy <= '0;
    else busy <= ((busy & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R1W register file, x0 hard-wired to zero, with busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module reg_file_sb import reg_file_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input logic clk,
  input logic n_rst,
  reg_file_sb_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [XLEN-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic hit1, hit2;
  always_ff @(posedge clk)
    if (n_rst) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (bus.we && bus.rd_addr != ZERO) regs[bus.rd_addr] <= bus.rd_data;
  always_comb begin
    hit1 = BYPASS && bus.we && bus.rd_addr != ZERO && bus.rd_addr == bus.rs1_addr;
    hit2 = BYPASS && bus.we && bus.rd_addr != ZERO && bus.rd_addr == bus.rs2_addr;
    bus.rs1_data = bus.rs1_addr == ZERO ? '0 : hit1 ? bus.rd_data : regs[bus.rs1_addr];
    bus.rs2_data = bus.rs2_addr == ZERO ? '0 : hit2 ? bus.rd_data : regs[bus.rs2_addr];
    bus.rs1_busy = hit1 ? bus.issue_valid && bus.issue_rd == bus.rs1_addr : busy[bus.rs1_addr];
    bus.rs2_busy = hit2 ? bus.issue_valid && bus.issue_rd == bus.rs2_addr : busy[bus.rs2_addr];
  end
  reg_file_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk(clk),
    .n_rst(n_rst),
    .we(bus.we),
    .rd_addr(bus.rd_addr),
    .issue_valid(bus.issue_valid),
    .issue_rd(bus.issue_rd),
    .busy(busy),
    .issue_conflict(bus.issue_conflict)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: randomized and directed checks of reg_file_sb against an array-based model
module tb_reg_file_sb;
  import reg_file_pkg::*;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;
  reg_file_sb_if #(.XLEN(32), .NUM_REGS(32)) bus();
  reg_file_sb #(.XLEN(32), .NUM_REGS(32)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  reg_data_t mreg [32];
  bit mbusy [32];

  function automatic reg_data_t exp_data(reg_addr_t a);
    if (a == 0) return '0;
    if (BYP && bus.we && bus.rd_addr == a) return bus.rd_data;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(reg_addr_t a);
    if (a == 0) return 1'b0;
    if (BYP && bus.we && bus.rd_addr == a) return bus.issue_valid && bus.issue_rd == a;
    return mbusy[a];
  endfunction

  task automatic idle();
    n_rst = 1'b0;
    bus.we = 1'b0;
    bus.rd_addr = '0;
    bus.rd_data = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd = '0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
  endtask

  task automatic tick();
    if (n_rst) begin
      foreach (mreg[i]) begin
        mreg[i] = '0;
        mbusy[i] = 1'b0;
      end
    end else begin
      if (bus.we && bus.rd_addr != 0) mreg[bus.rd_addr] = bus.rd_data;
      if (bus.we) mbusy[bus.rd_addr] = 1'b0;
      if (bus.issue_valid && bus.issue_rd != 0) mbusy[bus.issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 8; k++) begin
      bus.we = 1'b1;
      bus.rd_addr = reg_addr_t'($urandom_range(1, 31));
      bus.rd_data = $urandom;
      bus.issue_valid = 1'b1;
      bus.issue_rd = reg_addr_t'($urandom_range(1, 31));
      tick();
    end
    idle();
    n_rst = 1'b1;
    tick();
    tick();
    n_rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bus.rs1_addr = reg_addr_t'(a);
      bus.rs2_addr = reg_addr_t'(31 - a);
      #1;
      checks++;
      if (bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0) begin
        failures++;
        $display("FAIL reset_data a=%0d got=%h/%h exp=0", a, bus.rs1_data, bus.rs2_data);
      end
      checks++;
      if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_busy a=%0d got=%b/%b exp=0", a, bus.rs1_busy, bus.rs2_busy);
      end
    end
  endtask

  task automatic test_write_read();
    idle();
    bus.we = 1'b1;
    bus.rd_addr = 5'd5;
    bus.rd_data = 32'hDEADBEEF;
    tick();
    bus.we = 1'b0;
    bus.rs1_addr = 5'd5;
    #1;
    checks++;
    if (bus.rs1_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_x5 got=%h exp=deadbeef", bus.rs1_data);
    end
    bus.we = 1'b1;
    bus.rd_addr = 5'd0;
    bus.rd_data = 32'h1234;
    bus.rs2_addr = 5'd0;
    tick();
    bus.we = 1'b0;
    #1;
    checks++;
    if (bus.rs2_data !== 32'h0) begin
      failures++;
      $display("FAIL write_x0 got=%h exp=0", bus.rs2_data);
    end
  endtask

  task automatic test_same_cycle();
    idle();
    bus.we = 1'b1;
    bus.rd_addr = 5'd7;
    bus.rd_data = 32'hA5A5A5A5;
    bus.rs1_addr = 5'd7;
    #1;
    checks++;
    if (bus.rs1_data !== (BYP ? 32'hA5A5A5A5 : 32'h0)) begin
      failures++;
      $display("FAIL same_cycle_x7 got=%h exp=%h", bus.rs1_data, BYP ? 32'hA5A5A5A5 : 32'h0);
    end
    tick();
    bus.we = 1'b0;
    #1;
    checks++;
    if (bus.rs1_data !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL after_write_x7 got=%h exp=a5a5a5a5", bus.rs1_data);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd = 5'd3;
    #1;
    checks++;
    if (bus.issue_conflict !== 1'b0) begin
      failures++;
      $display("FAIL issue_x3_conflict got=%b exp=0", bus.issue_conflict);
    end
    tick();
    bus.issue_valid = 1'b0;
    bus.rs1_addr = 5'd3;
    #1;
    checks++;
    if (bus.rs1_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_x3_set got=%b exp=1", bus.rs1_busy);
    end
    bus.we = 1'b1;
    bus.rd_addr = 5'd3;
    bus.rd_data = 32'h33;
    #1;
    checks++;
    if (bus.rs1_busy !== !BYP) begin
      failures++;
      $display("FAIL busy_x3_wb_cycle got=%b exp=%b", bus.rs1_busy, !BYP);
    end
    tick();
    bus.we = 1'b0;
    #1;
    checks++;
    if (bus.rs1_busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_x3_clear got=%b exp=0", bus.rs1_busy);
    end
    bus.issue_valid = 1'b1;
    bus.issue_rd = 5'd0;
    bus.rs2_addr = 5'd0;
    #1;
    checks++;
    if (bus.issue_conflict !== 1'b0) begin
      failures++;
      $display("FAIL issue_x0_conflict got=%b exp=0", bus.issue_conflict);
    end
    tick();
    bus.issue_valid = 1'b0;
    #1;
    checks++;
    if (bus.rs2_busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_x0 got=%b exp=0", bus.rs2_busy);
    end
  endtask

  task automatic test_set_wins();
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd = 5'd9;
    tick();
    bus.we = 1'b1;
    bus.rd_addr = 5'd9;
    bus.rd_data = 32'h99;
    bus.rs1_addr = 5'd9;
    #1;
    checks++;
    if (bus.issue_conflict !== 1'b1) begin
      failures++;
      $display("FAIL set_wins_conflict got=%b exp=1", bus.issue_conflict);
    end
    checks++;
    if (bus.rs1_busy !== 1'b1) begin
      failures++;
      $display("FAIL set_wins_busy_during got=%b exp=1", bus.rs1_busy);
    end
    tick();
    bus.we = 1'b0;
    bus.issue_valid = 1'b0;
    #1;
    checks++;
    if (bus.rs1_busy !== 1'b1) begin
      failures++;
      $display("FAIL set_wins_busy_after got=%b exp=1", bus.rs1_busy);
    end
    checks++;
    if (bus.rs1_data !== 32'h99) begin
      failures++;
      $display("FAIL set_wins_data got=%h exp=99", bus.rs1_data);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd = 5'd4;
    tick();
    bus.issue_valid = 1'b0;
    n_rst = 1'b1;
    bus.we = 1'b1;
    bus.rd_addr = 5'd4;
    bus.rd_data = 32'hFF;
    tick();
    idle();
    bus.rs1_addr = 5'd4;
    #1;
    checks++;
    if (bus.rs1_data !== 32'h0 || bus.rs1_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got data=%h busy=%b exp data=0 busy=0", bus.rs1_data, bus.rs1_busy);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      n_rst = ($urandom_range(0, 49) == 0);
      bus.we = $urandom_range(0, 1) == 1;
      bus.rd_addr = reg_addr_t'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      bus.rd_data = $urandom;
      bus.issue_valid = $urandom_range(0, 1) == 1;
      bus.issue_rd = reg_addr_t'($urandom_range(0, 7));
      bus.rs1_addr = reg_addr_t'($urandom_range(0, 7));
      bus.rs2_addr = reg_addr_t'($urandom_range(0, 3) == 0 ? bus.rd_addr : $urandom_range(0, 31));
      #1;
      checks++;
      if (bus.rs1_data !== exp_data(bus.rs1_addr) || bus.rs2_data !== exp_data(bus.rs2_addr)) begin
        failures++;
        $display("FAIL rand_data k=%0d got=%h/%h exp=%h/%h", k, bus.rs1_data, bus.rs2_data,
                 exp_data(bus.rs1_addr), exp_data(bus.rs2_addr));
      end
      checks++;
      if (bus.rs1_busy !== exp_busy(bus.rs1_addr) || bus.rs2_busy !== exp_busy(bus.rs2_addr)) begin
        failures++;
        $display("FAIL rand_busy k=%0d got=%b/%b exp=%b/%b", k, bus.rs1_busy, bus.rs2_busy,
                 exp_busy(bus.rs1_addr), exp_busy(bus.rs2_addr));
      end
      checks++;
      if (bus.issue_conflict !== (bus.issue_valid && bus.issue_rd != 0 && mbusy[bus.issue_rd])) begin
        failures++;
        $display("FAIL rand_conflict k=%0d got=%b exp=%b", k, bus.issue_conflict,
                 bus.issue_valid && bus.issue_rd != 0 && mbusy[bus.issue_rd]);
      end
      tick();
    end
  endtask

  initial begin
    idle();
    n_rst = 1'b1;
    tick();
    tick();
    test_reset();
    test_write_read();
    test_same_cycle();
    test_scoreboard();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised integer register file with a per-register busy scoreboard, for the RISC-V core's decode/write-back path.
- Generalises the 1-bit enabled storage cell into an array of registers:
  - NUM_REGS entries, each XLEN wide.
  - Two combinational read ports and one write port.
  - x0 hard-wired to zero.
  - Busy bits track registers with an in-flight write, so decode can stall on RAW hazards.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers; must be a power of two and at least 2.
- ADDR_W, $clog2(NUM_REGS), register index width; derived, never overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- n_rst  in  1  reset, synchronous, active-high.
- rs1_addr  in  ADDR_W  read port 1 index.
- rs2_addr  in  ADDR_W  read port 2 index.
- rs1_data  out  XLEN  read port 1 data (combinational).
- rs2_data  out  XLEN  read port 2 data (combinational).
- rs1_busy  out  1  rs1 has a pending write.
- rs2_busy  out  1  rs2 has a pending write.
- we  in  1  write-back enable.
- rd_addr  in  ADDR_W  write-back index.
- rd_data  in  XLEN  write-back data.
- issue_valid  in  1  an instruction with destination issue_rd is issued this cycle.
- issue_rd  in  ADDR_W  destination to reserve.
- issue_conflict  out  1  issue_valid and issue_rd already busy (WAW); combinational.

Behaviour:
- Reset:
  - When n_rst=1 at a clock edge, all registers become 0 and all busy bits clear.
  - Reset overrides we and issue_valid in the same cycle.
  - Mid-operation reset discards pending reservations.
- Writes:
  - we=1 and rd_addr!=0: reg[rd_addr] <= rd_data at the edge.
  - Writes to x0 are ignored.
- Reads:
  - rs*_data = reg[rs*_addr]; rs*_addr==0 always yields 0.
  - Zero-cycle combinational path; no read latency.
- Scoreboard:
  - busy[i] is set at the edge when issue_valid=1 and issue_rd==i, for i!=0.
  - busy[i] is cleared at the edge when we=1 and rd_addr==i.
  - Simultaneous set and clear of the same index: set wins (new reservation follows old write-back).
  - busy[0] is always 0.
  - issue_valid with issue_rd==0 has no effect.
- Status outputs:
  - rs*_busy = busy[rs*_addr], subject to the bypass rule below.
  - issue_conflict = issue_valid & (issue_rd!=0) & busy[issue_rd].
  - On conflict the bit stays set (no counting); decode must stall, and the RF does not arbitrate.
- No wrap-around or overflow conditions: indices are always in range because NUM_REGS is a power of two.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - When we=1, rd_addr!=0 and rd_addr==rs*_addr, rs*_data = rd_data in the same cycle (write-through).
  - In that case rs*_busy=0 for that port, unless issue_valid reserves the same index in that cycle.
- Undefined:
  - Reads return the pre-write value during the write cycle; the new value is visible the cycle after.
  - rs*_busy reflects registered busy bits only.

Decomposition:
- Package reg_file_pkg holds:
  - XLEN_DEF=32 and NUM_REGS_DEF=32.
  - typedef reg_addr_t (logic [4:0]) and typedef reg_data_t (logic [31:0]).
  - localparam REG_ZERO=0.
- Sub-module reg_file_scoreboard:
  - Owns the NUM_REGS busy vector and its set/clear/priority logic.
  - Outputs busy vector and issue_conflict.
- The top module holds the data array and read muxes.

Test Plan:
- Reset: drive n_rst=1 for 2 cycles after random writes -> every rs*_data=0 and every rs*_busy=0.
- Write/read: we=1, rd_addr=5, rd_data=0xDEADBEEF; next cycle rs1_addr=5 -> 0xDEADBEEF. Write 0x1234 to x0 -> rs2_addr=0 reads 0.
- Same-cycle write+read of x7=0xA5A5A5A5:
  - Without REG_FILE_BYPASS_EN: old value 0 that cycle, 0xA5A5A5A5 next cycle.
  - With REG_FILE_BYPASS_EN: 0xA5A5A5A5 in the write cycle.
- Scoreboard: issue_valid=1, issue_rd=3 -> rs1_busy=1 at rs1_addr=3 next cycle. Later we=1, rd_addr=3 -> busy 0 the following cycle. issue_rd=0 -> never busy.
- Set-wins: with busy[9]=1, assert we to x9 and issue_valid with issue_rd=9 in the same cycle -> busy[9]=1 afterwards, and issue_conflict=1 during that cycle.
- Reset mid-operation: busy[4]=1 with n_rst=1 and we=1 to x4 with 0xFF -> after the edge x4=0 and busy[4]=0.
